// File: rtl/vga_pkg.sv
// Shared types and helpers for the vga game front end.
// The button FSM state enum and a counter-width helper live here.
package vga_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    HELD_DELAY,
    HELD_REPEAT
  } btn_state_t;

  // Bits needed to count up to max(a, b) - 1, never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchroniser, debounce counter,
// press/release FSM and auto-repeat hold counter.
module button_channel
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES, DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [1:0]        sync;
  logic              s;
  logic [DB_W-1:0]   db_cnt;
  logic              accept_rise;
  logic              accept_fall;
  btn_state_t        state;
  btn_state_t        state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              press_next;
  logic              release_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], btn_raw};
    end
  end

  assign s = sync[1];

  // A change is accepted on the cycle the counter sits at its terminal value
  // while the synchronised input still disagrees with the debounced level.
  assign accept_rise = (s != btn_level) && (db_cnt == DB_LAST) && s;
  assign accept_fall = (s != btn_level) && (db_cnt == DB_LAST) && !s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (s == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt    <= '0;
      btn_level <= s;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RELEASED;
      hold_cnt    <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      btn_press   <= press_next;
      btn_release <= release_next;
    end
  end

  // The hold counter and state advance independently of repeat_en.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    unique case (state)
      RELEASED: begin
        hold_next = '0;
        if (accept_rise) begin
          state_next = HELD_DELAY;
        end
      end
      HELD_DELAY: begin
        if (accept_fall) begin
          state_next = RELEASED;
          hold_next  = '0;
        end else if (hold_cnt == DELAY_LAST) begin
          state_next = HELD_REPEAT;
          hold_next  = '0;
        end else begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end
      HELD_REPEAT: begin
        if (accept_fall) begin
          state_next = RELEASED;
          hold_next  = '0;
        end else if (hold_cnt == PERIOD_LAST) begin
          hold_next = '0;
        end else begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_next = RELEASED;
        hold_next  = '0;
      end
    endcase
  end

  // A release always wins over a repeat strobe due on the same cycle.
  always_comb begin
    press_next   = 1'b0;
    release_next = 1'b0;
    unique case (state)
      RELEASED: begin
        press_next = accept_rise;
      end
      HELD_DELAY: begin
        if (accept_fall) begin
          release_next = 1'b1;
        end else if (hold_cnt == DELAY_LAST) begin
          press_next = repeat_en;
        end
      end
      HELD_REPEAT: begin
        if (accept_fall) begin
          release_next = 1'b1;
        end else if (hold_cnt == PERIOD_LAST) begin
          press_next = repeat_en;
        end
      end
      default: begin
        press_next   = 1'b0;
        release_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// N independent push-button channels, each a button_channel instance.
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_channel (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .repeat_en  (repeat_en[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// button traffic, all compared against a cycle-level behavioural model.
module tb_button_conditioner;

  localparam int NB = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] repeat_en = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int vectors = 0;
  int miscompares = 0;

  // Model state: raw input seen two edges late, run length of disagreement,
  // debounced level, and cycles elapsed since the accepted press.
  bit m_sync1 [NB];
  bit m_sync2 [NB];
  int m_run   [NB];
  bit m_level [NB];
  bit m_held  [NB];
  int m_age   [NB];
  logic [NB-1:0] m_press;
  logic [NB-1:0] m_release;
  logic [NB-1:0] m_lvl_vec;

  logic [NB-1:0] obs_level;
  logic [NB-1:0] obs_press;
  logic [NB-1:0] obs_release;

  button_conditioner #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  function automatic bit repeatDue(input int age);
    return (age == RD) || (age > RD && ((age - RD) % RP) == 0);
  endfunction

  task automatic modelStep(input logic [NB-1:0] raw, input logic [NB-1:0] ren);
    bit rose;
    bit fell;
    for (int c = 0; c < NB; c++) begin
      m_press[c]   = 1'b0;
      m_release[c] = 1'b0;
      if (rst) begin
        m_sync1[c] = 0; m_sync2[c] = 0; m_run[c] = 0;
        m_level[c] = 0; m_held[c] = 0;  m_age[c] = 0;
      end else begin
        rose = 0;
        fell = 0;
        if (m_sync2[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_level[c] = m_sync2[c];
            m_run[c]   = 0;
            rose = m_level[c];
            fell = !m_level[c];
          end
        end else begin
          m_run[c] = 0;
        end
        if (rose) begin
          m_press[c] = 1'b1;
          m_held[c]  = 1;
          m_age[c]   = 0;
        end else if (fell) begin
          m_release[c] = 1'b1;
          m_held[c]    = 0;
        end else if (m_held[c]) begin
          m_age[c]++;
          if (ren[c] && repeatDue(m_age[c])) m_press[c] = 1'b1;
        end
        m_sync2[c] = m_sync1[c];
        m_sync1[c] = raw[c];
      end
      m_lvl_vec[c] = m_level[c];
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare at
  // the following falling edge.
  task automatic applyStimulus(input logic [NB-1:0] raw, input logic [NB-1:0] ren);
    btn_raw   = raw;
    repeat_en = ren;
    @(posedge clk);
    modelStep(raw, ren);
    @(negedge clk);
    obs_level   = btn_level;
    obs_press   = btn_press;
    obs_release = btn_release;
    checkOutput("level", 32'(obs_level), 32'(m_lvl_vec));
    checkOutput("press", 32'(obs_press), 32'(m_press));
    checkOutput("release", 32'(obs_release), 32'(m_release));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0);
  endtask

  initial begin
    int first;
    int count;
    logic [31:0] mask;
    logic [NB-1:0] ren;
    int remain [NB];
    logic [NB-1:0] rraw;
    logic [NB-1:0] rren;

    applyStimulus('0, '0);
    applyStimulus('0, '0);
    rst = 1'b0;
    idle(3);

    // Clean press on ch0 without repeat.
    first = -1; count = 0;
    for (int i = 0; i < 35; i++) begin
      applyStimulus(2'b01, 2'b00);
      if (obs_press[0]) begin
        count++;
        if (first < 0) first = i;
      end
    end
    checkOutput("press_latency", 32'(first), 32'd5);
    checkOutput("press_count", 32'(count), 32'd1);
    first = -1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(2'b00, 2'b00);
      if (obs_release[0] && first < 0) first = i;
    end
    checkOutput("release_latency", 32'(first), 32'd5);

    // Glitches on ch1: three cycles rejected, four accepted.
    count = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus((i < 3) ? 2'b10 : 2'b00, 2'b00);
      if (obs_level[1] || obs_press[1] || obs_release[1]) count++;
    end
    checkOutput("glitch3_activity", 32'(count), 32'd0);
    count = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus((i < 4) ? 2'b10 : 2'b00, 2'b00);
      if (obs_press[1]) count++;
      if (obs_release[1]) count += 16;
    end
    checkOutput("pulse4_press_release", 32'(count), 32'd17);

    // Auto-repeat with repeat_en held high.
    mask = '0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(2'b01, 2'b01);
      if (i >= 5 && obs_press[0]) mask[i-5] = 1'b1;
    end
    checkOutput("repeat_offsets", mask, 32'h0049_2401);
    idle(12);

    // Repeat enable dropped at offset 14 and restored at offset 21.
    mask = '0;
    for (int i = 0; i < 30; i++) begin
      ren = ((i - 5) >= 14 && (i - 5) < 21) ? 2'b00 : 2'b01;
      applyStimulus(2'b01, ren);
      if (i >= 5 && obs_press[0]) mask[i-5] = 1'b1;
    end
    checkOutput("toggle_offsets", mask, 32'h0040_2401);
    idle(12);

    // Accepted fall lands on a due repeat at offset 13.
    for (int i = 0; i < 24; i++) begin
      applyStimulus((i < 13) ? 2'b01 : 2'b00, 2'b01);
      if (i == 18) begin
        checkOutput("collide_release", 32'(obs_release[0]), 32'd1);
        checkOutput("collide_press", 32'(obs_press[0]), 32'd0);
      end
    end
    idle(4);

    // Asynchronous reset in the middle of a hold on both channels.
    for (int i = 0; i < 20; i++) applyStimulus(2'b11, 2'b11);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", 32'({btn_level, btn_press, btn_release}), 32'd0);
    applyStimulus(2'b11, 2'b11);
    applyStimulus(2'b11, 2'b11);
    rst = 1'b0;
    first = -1; count = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(2'b11, 2'b00);
      if (obs_press == 2'b11 && first < 0) first = i;
      if (obs_release != '0) count++;
    end
    checkOutput("rearm_latency", 32'(first), 32'd5);
    checkOutput("rearm_no_release", 32'(count), 32'd0);
    idle(12);

    // Random button traffic with mixed hold lengths and occasional resets.
    rraw = '0; rren = '0;
    for (int c = 0; c < NB; c++) remain[c] = 1;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < NB; c++) begin
        remain[c]--;
        if (remain[c] <= 0) begin
          rraw[c] = ~rraw[c];
          remain[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                  : int'($urandom_range(1, 9));
        end
        if ($urandom_range(0, 19) == 0) rren[c] = ~rren[c];
      end
      rst = ($urandom_range(0, 399) == 0);
      applyStimulus(rraw, rren);
    end
    rst = 1'b0;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
